// File: rtl/msg_pkg.sv
// Shared widths and the slot record for the message queue.
package msg_pkg;
  localparam int MSG_W  = 256;
  localparam int MASK_W = 32;
  localparam int LEN_W  = 6;

  typedef struct packed {
    logic [MSG_W-1:0] data;
    logic [LEN_W-1:0] len;
  } slot_t;
endpackage

// File: rtl/msg_mask_len.sv
// Combinational check that a byte mask is contiguous from bit 0, plus its byte length.
module msg_mask_len
  import msg_pkg::*;
(
  input  logic [MASK_W-1:0] mask_i,
  output logic              legal_o,
  output logic [LEN_W-1:0]  len_o
);

  logic [MASK_W-1:0] mask_inc;

  assign mask_inc = mask_i + 1'b1;

  always_comb begin
    // 2^n-1 masks have no bits in common with themselves plus one
    legal_o = (mask_i != '0) && ((mask_i & mask_inc) == '0);
    len_o   = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask_i[i]) len_o = LEN_W'(i + 1);
    end
  end

endmodule

// File: rtl/msg_queue.sv
// Message FIFO with mask validation, overflow dropping and saturating event counters.
module msg_queue
  import msg_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [MSG_W-1:0]  in_data,
  input  logic [MASK_W-1:0] in_bytemask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MSG_W-1:0]  out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic [LVL_W-1:0]  level,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  err_count
);

  slot_t              slot_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               mask_legal;
  logic [LEN_W-1:0]   mask_len;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop_evt;
  logic               err_evt;

  msg_mask_len u_mask_len (
    .mask_i  (in_bytemask),
    .legal_o (mask_legal),
    .len_o   (mask_len)
  );

  assign full      = (level_q == LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees the slot, so a full queue can still accept
  assign push      = in_valid && mask_legal && (!full || pop);
  assign drop_evt  = in_valid && mask_legal && full && !pop;
  assign err_evt   = in_valid && !mask_legal;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
    if (drop_evt && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    if (err_evt && err_cnt_q != '1)   err_cnt_d  = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Slot contents are only meaningful while counted by level, so no reset
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      slot_q[wr_ptr_q] <= '{data: in_data, len: mask_len};
    end
  end

  assign out_data   = slot_q[rd_ptr_q].data;
  assign out_len    = slot_q[rd_ptr_q].len;
  assign level      = level_q;
  assign drop_count = drop_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_msg_queue.sv
// Self-checking bench for msg_queue: directed table, corner sequences and a random run against a queue model.
module tb_msg_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [255:0] in_data;
  logic [31:0]  in_bytemask;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [5:0]   out_len;
  logic [2:0]   level;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] d;
    int           len;
  } ent_t;

  ent_t mq[$];
  int   m_drop;
  int   m_err;

  msg_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_bytemask (in_bytemask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_len     (out_len),
    .level       (level),
    .drop_count  (drop_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    logic [32:0] one;
    one = 33'd1;
    return 32'((one << n) - 33'd1);
  endfunction

  // Legal iff the mask equals 2^n-1 for some n in 1..32; returns n or 0
  function automatic int model_len(input logic [31:0] m);
    for (int n = 1; n <= 32; n++) if (m == mask_of(n)) return n;
    return 0;
  endfunction

  task automatic step(input logic v, input logic [31:0] m, input logic r,
                      input logic rst, input logic [255:0] d);
    bit   pop;
    int   n;
    ent_t e;
    reset = rst; in_valid = v; in_bytemask = m; out_ready = r; in_data = d;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_drop = 0; m_err = 0;
    end else begin
      pop = (mq.size() > 0) && r;
      n   = model_len(m);
      if (v && n == 0) begin
        if (m_err < CMAX) m_err++;
      end else if (v && (mq.size() < DEPTH || pop)) begin
        if (pop) void'(mq.pop_front());
        pop = 0;
        e.d = d; e.len = n;
        mq.push_back(e);
      end else if (v) begin
        if (m_drop < CMAX) m_drop++;
      end
      if (pop) void'(mq.pop_front());
    end
    #1;
    chk("model_level", 256'(level), 256'(mq.size()));
    chk("model_out_valid", 256'(out_valid), 256'(mq.size() != 0));
    chk("model_drop", 256'(drop_count), 256'(m_drop));
    chk("model_err", 256'(err_count), 256'(m_err));
    if (mq.size() != 0) begin
      chk("model_out_data", out_data, mq[0].d);
      chk("model_out_len", 256'(out_len), 256'(mq[0].len));
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] m;
    logic        r;
    int          lvl;
    logic        ov;
    int          len;
    int          err;
  } vec_t;

  vec_t tbl[6];
  logic [255:0] dv[6];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_bytemask = '0; out_ready = 1'b0;
    tbl[0] = '{1'b1, 32'h1,        1'b1, 1, 1'b1, 1,  0};
    tbl[1] = '{1'b1, 32'hFF,       1'b1, 1, 1'b1, 8,  0};
    tbl[2] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1, 1'b1, 32, 0};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 0, 1'b0, 0,  0};
    tbl[4] = '{1'b1, 32'h0,        1'b1, 0, 1'b0, 0,  1};
    tbl[5] = '{1'b1, 32'h5,        1'b1, 0, 1'b0, 0,  2};

    // Reset state
    step(1'b0, '0, 1'b0, 1'b1, '0);
    chk("reset_level", 256'(level), 256'd0);
    chk("reset_out_valid", 256'(out_valid), 256'd0);
    chk("reset_drop", 256'(drop_count), 256'd0);
    chk("reset_err", 256'(err_count), 256'd0);

    // In-order lengths with one-cycle latency, then illegal masks
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].m, tbl[i].r, 1'b0, rnd256());
      chk($sformatf("tbl%0d_level", i), 256'(level), 256'(tbl[i].lvl));
      chk($sformatf("tbl%0d_out_valid", i), 256'(out_valid), 256'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_len", i), 256'(out_len), 256'(tbl[i].len));
      chk($sformatf("tbl%0d_err", i), 256'(err_count), 256'(tbl[i].err));
      chk($sformatf("tbl%0d_drop", i), 256'(drop_count), 256'd0);
    end

    // Overflow: six pushes into four slots, then drain in order
    step(1'b0, '0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      dv[i] = rnd256();
      step(1'b1, 32'hF, 1'b0, 1'b0, dv[i]);
    end
    chk("ovf_level", 256'(level), 256'd4);
    chk("ovf_drop", 256'(drop_count), 256'd2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_head%0d", i), out_data, dv[i]);
      chk($sformatf("ovf_len%0d", i), 256'(out_len), 256'd4);
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    chk("ovf_empty", 256'(out_valid), 256'd0);

    // Push and pop together while full
    step(1'b0, '0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) dv[i] = rnd256();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3, 1'b0, 1'b0, dv[i]);
    step(1'b1, 32'h7, 1'b1, 1'b0, dv[4]);
    chk("full_pp_level", 256'(level), 256'd4);
    chk("full_pp_drop", 256'(drop_count), 256'd0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("full_pp_head%0d", i), out_data, dv[i]);
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    chk("full_pp_new_head", out_data, dv[4]);
    chk("full_pp_new_len", 256'(out_len), 256'd3);

    // Reset mid-operation with in_valid high
    step(1'b0, '0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1, 1'b0, 1'b0, rnd256());
    step(1'b1, 32'h6, 1'b0, 1'b0, rnd256());
    chk("mid_level3", 256'(level), 256'd3);
    chk("mid_err1", 256'(err_count), 256'd1);
    step(1'b1, 32'hFF, 1'b0, 1'b1, rnd256());
    chk("mid_rst_level", 256'(level), 256'd0);
    chk("mid_rst_out_valid", 256'(out_valid), 256'd0);
    chk("mid_rst_drop", 256'(drop_count), 256'd0);
    chk("mid_rst_err", 256'(err_count), 256'd0);

    // Counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1, 1'b0, 1'b0, rnd256());
    for (int i = 0; i < 20; i++) step(1'b1, 32'h1, 1'b0, 1'b0, rnd256());
    for (int i = 0; i < 20; i++) step(1'b1, 32'h2, 1'b0, 1'b0, rnd256());
    chk("sat_drop", 256'(drop_count), 256'(CMAX));
    chk("sat_err", 256'(err_count), 256'(CMAX));
    chk("sat_level", 256'(level), 256'd4);

    // Random traffic against the model
    step(1'b0, '0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] m;
      if ($urandom_range(3) == 0) m = $urandom;
      else m = mask_of(int'($urandom_range(32, 1)));
      step(1'($urandom_range(1)), m, 1'($urandom_range(2) != 0),
           ($urandom_range(60) == 0), rnd256());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
